// File: rtl/dice_roll_if.sv
// Roller-side link of the dice roll sequencer: die type select, single-cycle
// roll strobe and the roller's result byte.
interface dice_roll_if;
  logic       roll;
  logic [1:0] die_select;
  logic [7:0] rolled_number;

  modport master (
    output roll,
    output die_select,
    input  rolled_number
  );

  modport slave (
    input  roll,
    input  die_select,
    output rolled_number
  );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Initiator for the dice roller: issues N roll pulses, accumulates sum/min/max
// and flags out-of-range results. Define DICE_DROP_LOWEST_EN to drop the lowest die.
module dice_roll_sequencer #(
  parameter int unsigned MAX_DICE = 15,
  parameter int unsigned SUM_W    = 9,
  parameter int unsigned ROLL_GAP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       die_sel_in,
  input  logic [3:0]       num_dice,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic [7:0]       min_roll,
  output logic [7:0]       max_roll,
  output logic             range_err,
  dice_roll_if.master      rif
);

  localparam int unsigned     GAP_W    = (ROLL_GAP > 1) ? $clog2(ROLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((ROLL_GAP > 0) ? ROLL_GAP - 1 : 0);
  localparam logic [3:0]      MAX_N    = (MAX_DICE > 15) ? 4'd15 : 4'(MAX_DICE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_CAPTURE,
    S_GAP,
    S_FINAL
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       die_select_q, die_select_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       max_q, max_d;
  logic             err_q, err_d;
  logic [GAP_W-1:0] gap_q, gap_d;

`ifdef DICE_DROP_LOWEST_EN
  logic             multi_q, multi_d;
`endif

  logic [3:0]       n_clamped;
  logic [7:0]       face;
  logic [SUM_W-1:0] sum_acc;
  logic [7:0]       min_acc;
  logic [7:0]       max_acc;
  logic [3:0]       remaining_dec;
  logic             bad_roll;

  assign n_clamped = (num_dice > MAX_N) ? MAX_N : num_dice;

  always_comb begin
    face = 8'd4;
    case (die_select_q)
      2'b00: face = 8'd4;
      2'b01: face = 8'd6;
      2'b10: face = 8'd8;
      2'b11: face = 8'd20;
      default: face = 8'd4;
    endcase
  end

  assign sum_acc       = sum_q + SUM_W'(rif.rolled_number);
  assign min_acc       = (rif.rolled_number < min_q) ? rif.rolled_number : min_q;
  assign max_acc       = (rif.rolled_number > max_q) ? rif.rolled_number : max_q;
  assign remaining_dec = remaining_q - 4'd1;
  assign bad_roll      = (rif.rolled_number == 8'd0) || (rif.rolled_number > face);

  always_comb begin
    state_d      = state_q;
    die_select_d = die_select_q;
    remaining_d  = remaining_q;
    sum_d        = sum_q;
    min_d        = min_q;
    max_d        = max_q;
    err_d        = err_q;
    gap_d        = gap_q;
`ifdef DICE_DROP_LOWEST_EN
    multi_d      = multi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          die_select_d = die_sel_in;
          remaining_d  = n_clamped;
          sum_d        = '0;
          err_d        = 1'b0;
          max_d        = '0;
`ifdef DICE_DROP_LOWEST_EN
          multi_d      = (n_clamped >= 4'd2);
`endif
          // Zero-dice min forcing is applied here so results are already
          // final while done is high in FINAL.
          if (n_clamped == 4'd0) begin
            min_d   = '0;
            state_d = S_FINAL;
          end else begin
            min_d   = '1;
            state_d = S_PULSE;
          end
        end
      end

      S_PULSE: state_d = S_CAPTURE;

      S_CAPTURE: begin
        min_d       = min_acc;
        max_d       = max_acc;
        err_d       = err_q | bad_roll;
        remaining_d = remaining_dec;
        sum_d       = sum_acc;
        if (remaining_dec != 4'd0) begin
          if (ROLL_GAP > 0) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            state_d = S_PULSE;
          end
        end else begin
          // Drop-lowest is folded into the last capture so sum is valid with done.
`ifdef DICE_DROP_LOWEST_EN
          if (multi_q) begin
            sum_d = sum_acc - SUM_W'(min_acc);
          end
`else
          sum_d = sum_acc;
`endif
          state_d = S_FINAL;
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_PULSE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_FINAL: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      die_select_q <= '0;
      remaining_q  <= '0;
      sum_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      err_q        <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      die_select_q <= die_select_d;
      remaining_q  <= remaining_d;
      sum_q        <= sum_d;
      min_q        <= min_d;
      max_q        <= max_d;
      err_q        <= err_d;
      gap_q        <= gap_d;
    end
  end

`ifdef DICE_DROP_LOWEST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_q <= 1'b0;
    end else begin
      multi_q <= multi_d;
    end
  end
`endif

  // roll decodes straight from the state register so async reset kills it at once.
  assign rif.roll       = (state_q == S_PULSE);
  assign rif.die_select = die_select_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINAL);
  assign sum            = sum_q;
  assign min_roll       = min_q;
  assign max_roll       = max_q;
  assign range_err      = err_q;

  a_roll_single : assert property (@(posedge clk) disable iff (!rst_n)
    rif.roll |=> !rif.roll);
  a_done_busy : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> busy);

endmodule
